// File: rtl/maria_pkg.sv
// Shared Maria video constants: line-buffer entry width, pixels per line,
// pixel address width, and the pixel entry type.
package maria_pkg;

    localparam int PIXW = 5;
    localparam int NPIX = 160;
    localparam int AW   = 8;

    typedef logic [PIXW-1:0] pix_t;

endpackage

// File: rtl/line_ram_bank.sv
// One line-buffer bank: single write port and a registered (1 clk) read port.
module line_ram_bank
    import maria_pkg::*;
#(
    parameter int DEPTH  = NPIX,
    parameter int WIDTH  = PIXW,
    parameter int ADDR_W = AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_buffer_scan.sv
// Ping-pong line buffer: the back bank takes DMA writes for the next line while
// the front bank is scanned out and cleared behind the read; banks swap on lrc.
module line_buffer_scan
    import maria_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            mclk1,
    input  logic            border,
    input  logic            vblank,
    input  logic            lrc,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [PIXW-1:0] wr_data,
    output logic [PIXW-1:0] pix_data,
    output logic            pix_valid,
    output logic [AW-1:0]   pix_x,
    output logic            disp_sel,
    output logic            busy,
    output logic            wr_err
);

    typedef enum logic [1:0] {CLEAR, IDLE, SCAN} state_t;

    state_t        state;
    logic [AW-1:0] x;
    logic [AW-1:0] clr_addr;
    logic          phase;

    logic          scan_tick;
    logic          rd_p0;
    logic          clr_p0;
    logic          swap;
    logic          addr_ok;
    logic          wr_ok;

    logic          rd_p1;
    logic          vld_p1;
    logic          sel_p1;
    logic [AW-1:0] x_p1;

    logic          bank_we    [2];
    logic [AW-1:0] bank_waddr [2];
    pix_t          bank_wdata [2];
    pix_t          bank_q     [2];
    pix_t          q_sel;

    // The IDLE->SCAN tick is itself pixel 0 phase 0, so IDLE reads too.
    assign scan_tick = mclk1 && !border && (state != CLEAR);
    assign rd_p0     = scan_tick && !phase;
    assign clr_p0    = scan_tick && phase;
    assign swap      = mclk1 && lrc && (state != CLEAR);
    assign addr_ok   = (wr_addr < AW'(NPIX));
    assign wr_ok     = wr_en && !busy && addr_ok;
    assign q_sel     = sel_p1 ? bank_q[1] : bank_q[0];

    // Write-port mux per bank: clear sweep, clear-after-read on the front bank,
    // or DMA write on the back bank (pre-swap disp_sel decides which is which).
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = 1'b0;
            bank_waddr[b] = x;
            bank_wdata[b] = '0;
            if (reset) begin
                bank_we[b] = 1'b0;
            end else if (state == CLEAR) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = clr_addr;
            end else if (1'(b) == disp_sel) begin
                bank_we[b] = clr_p0;
            end else if (wr_ok) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = wr_addr;
                bank_wdata[b] = wr_data;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        line_ram_bank #(
            .DEPTH  (NPIX),
            .WIDTH  (PIXW),
            .ADDR_W (AW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .waddr (bank_waddr[g]),
            .wdata (bank_wdata[g]),
            .re    (rd_p0),
            .raddr (x),
            .rdata (bank_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            x         <= '0;
            phase     <= 1'b0;
            disp_sel  <= 1'b0;
            busy      <= 1'b1;
            wr_err    <= 1'b0;
            rd_p1     <= 1'b0;
            vld_p1    <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
        end else begin
            wr_err <= wr_en && !wr_ok;
            if (swap)
                disp_sel <= !disp_sel;

            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == AW'(NPIX - 1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        clr_addr <= '0;
                    end
                end
                IDLE: begin
                    if (scan_tick) begin
                        state <= SCAN;
                        phase <= 1'b1;
                    end
                end
                SCAN: begin
                    if (mclk1) begin
                        if (border) begin
                            state <= IDLE;
                            x     <= '0;
                            phase <= 1'b0;
                        end else begin
                            phase <= !phase;
                            if (phase && (x != AW'(NPIX - 1)))
                                x <= x + 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase

            // p0 -> p1: bank read in flight
            rd_p1  <= rd_p0;
            vld_p1 <= rd_p0 && !vblank;

            // p1 -> output: register the read result, held until the next read lands
            if (rd_p1) begin
                pix_valid <= vld_p1;
                pix_data  <= vld_p1 ? q_sel : '0;
                pix_x     <= x_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        x_p1   <= x;
        sel_p1 <= disp_sel;
    end

endmodule

// File: tb/tb_line_buffer_scan.sv
// Directed bench for line_buffer_scan: clear sweep, ramp scan-out, clear-after-read,
// vblank masking, swap/write collision, bad address, and mid-scan reset.
module tb_line_buffer_scan;
    import maria_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            mclk1;
    logic            border;
    logic            vblank;
    logic            lrc;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [PIXW-1:0] wr_data;
    logic [PIXW-1:0] pix_data;
    logic            pix_valid;
    logic [AW-1:0]   pix_x;
    logic            disp_sel;
    logic            busy;
    logic            wr_err;

    int n_vec = 0;
    int n_bad = 0;

    line_buffer_scan dut (
        .clk       (clk),
        .reset     (reset),
        .mclk1     (mclk1),
        .border    (border),
        .vblank    (vblank),
        .lrc       (lrc),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .disp_sel  (disp_sel),
        .busy      (busy),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One mclk1 tick followed by three idle clocks; ends on a falling edge.
    task automatic mtick(input logic brd, input logic l);
        mclk1  = 1'b1;
        border = brd;
        lrc    = l;
        @(negedge clk);
        mclk1 = 1'b0;
        lrc   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic write_px(input int addr, input logic [PIXW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_ramp();
        for (int i = 0; i < NPIX; i++)
            write_px(i, PIXW'(i & 31));
    endtask

    // Count clocks with busy high, starting from a count already elapsed.
    task automatic wait_clear(input int start);
        int n;
        n = start;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_vec("busy_len", n, 160);
        @(negedge clk);
    endtask

    // mode 0: all zero, mode 1: ramp i&31, mode 2: zero except pixel 10 = 0x15
    task automatic scan(input int npx, input logic vb, input int mode);
        logic [31:0] exp;
        vblank = vb;
        for (int i = 0; i < npx; i++) begin
            mtick(1'b0, 1'b0);
            mtick(1'b0, 1'b0);
            if (mode == 1)
                exp = i & 31;
            else if (mode == 2 && i == 10)
                exp = 32'h15;
            else
                exp = 0;
            if (vb)
                exp = 0;
            check_vec($sformatf("pix_data[%0d]", i), pix_data, exp);
            check_vec($sformatf("pix_x[%0d]", i), pix_x, i);
            check_vec($sformatf("pix_valid[%0d]", i), pix_valid, !vb);
        end
        if (npx == NPIX)
            mtick(1'b1, 1'b0);
        vblank = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        mclk1   = 1'b0;
        border  = 1'b1;
        vblank  = 1'b0;
        lrc     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);

        check_vec("rst_pix_data", pix_data, 0);
        check_vec("rst_pix_valid", pix_valid, 0);
        check_vec("rst_pix_x", pix_x, 0);
        check_vec("rst_disp_sel", disp_sel, 0);
        check_vec("rst_busy", busy, 1);
        check_vec("rst_wr_err", wr_err, 0);

        // Release reset with a write attempt during the clear sweep
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 8'd5;
        wr_data = 5'd7;
        @(posedge clk);
        #1;
        check_vec("busy_wr_err", wr_err, 1);
        check_vec("busy_early", busy, 1);
        wr_en = 1'b0;
        wait_clear(1);
        check_vec("wr_err_pulse", wr_err, 0);

        // Ramp into back bank 1, swap, scan out
        write_ramp();
        check_vec("ramp_wr_err", wr_err, 0);
        mtick(1'b1, 1'b1);
        check_vec("swap1_disp_sel", disp_sel, 1);
        scan(NPIX, 1'b0, 1);

        // Swap away and back, rescan the same bank: cleared after read
        mtick(1'b1, 1'b1);
        check_vec("swap2_disp_sel", disp_sel, 0);
        mtick(1'b1, 1'b1);
        check_vec("swap3_disp_sel", disp_sel, 1);
        scan(NPIX, 1'b0, 0);

        // Ramp into bank 0, scan in vblank, then rescan
        write_ramp();
        mtick(1'b1, 1'b1);
        check_vec("swap4_disp_sel", disp_sel, 0);
        scan(NPIX, 1'b1, 1);
        mtick(1'b1, 1'b1);
        mtick(1'b1, 1'b1);
        check_vec("swap6_disp_sel", disp_sel, 0);
        scan(NPIX, 1'b0, 0);

        // Write coincident with swap lands in pre-swap back bank (bank 1)
        wr_en   = 1'b1;
        wr_addr = 8'd10;
        wr_data = 5'h15;
        mclk1   = 1'b1;
        lrc     = 1'b1;
        border  = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        mclk1 = 1'b0;
        lrc   = 1'b0;
        check_vec("coll_wr_err", wr_err, 0);
        check_vec("coll_disp_sel", disp_sel, 1);
        repeat (3) @(negedge clk);
        scan(NPIX, 1'b0, 2);

        write_px(160, 5'h1f);
        check_vec("badaddr_wr_err", wr_err, 1);
        @(negedge clk);
        check_vec("badaddr_wr_err_end", wr_err, 0);

        // Fill back bank 0, scan bank 1 to pixel 80, then reset
        write_ramp();
        scan(80, 1'b0, 0);
        reset  = 1'b1;
        border = 1'b1;
        @(negedge clk);
        check_vec("midrst_pix_valid", pix_valid, 0);
        check_vec("midrst_disp_sel", disp_sel, 0);
        check_vec("midrst_busy", busy, 1);
        reset = 1'b0;
        wait_clear(0);
        scan(NPIX, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
